fifo_rr_arbiter: RTL and testbench

Round-robin write arbiter and read sequencer for the team's 8-entry, 8-bit FIFO. It shares the single FIFO write port among NUM_REQ producers and gates the consumer's read requests. It owns the authoritative occupancy count and drives the FIFO's wr_enb, data_in, rd_enb and rst, so no decision depends on the FIFO's own status flags.

---
 rtl/fifo_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin write arbiter and read sequencer for the shared FIFO
//
// Shares the single FIFO write port among NUM_REQ producers and gates consumer pops.
// The authoritative occupancy count lives here, so no decision relies on the FIFO's flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous clear of occupancy, pointer and FIFO contents
//   req, req_data       per-producer request and data (producer i at [i*DATA_W +: DATA_W])
//   gnt                 combinational one-hot grant; transfer when req[i] & gnt[i]
//   pop, pop_ack        consumer read request and its combinational acceptance
//   rd_valid            FIFO data_out valid this cycle
//   fifo_wr_enb/_data   registered FIFO write port
//   fifo_rd_enb         registered FIFO read enable
//   fifo_rst            registered FIFO reset (rst | flush)
//   occupancy, full, empty   accepted-but-not-popped entry count and its flags
module fifo_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      pop,
    output logic                      pop_ack,
    output logic                      rd_valid,
    output logic                      fifo_wr_enb,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      fifo_rd_enb,
    output logic                      fifo_rst,
    output logic [CNT_W-1:0]          occupancy,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  sel_idx;
    logic [PTR_W:0]    scan_idx;
    logic              gnt_any;
    logic              do_rd;
    logic [DATA_W-1:0] req_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign full    = (occupancy == CNT_W'(DEPTH));
    assign empty   = (occupancy == '0);
    // No bypass: a pop is judged only on entries already accepted.
    assign pop_ack = !empty && !flush && !rst;
    assign do_rd   = pop && pop_ack;

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ; the extra scan bit
    // holds the unwrapped sum so non-power-of-two NUM_REQ wraps correctly.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        sel_idx  = '0;
        if (!full && !flush && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                    scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
                end
                sel_idx = scan_idx[PTR_W-1:0];
                if (!gnt_any && req[sel_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = sel_idx;
                end
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        fifo_rst <= rst | flush;
        if (rst) begin
            occupancy    <= '0;
            rr_ptr       <= '0;
            fifo_wr_enb  <= 1'b0;
            fifo_wr_data <= '0;
            fifo_rd_enb  <= 1'b0;
            rd_valid     <= 1'b0;
        end else if (flush) begin
            // In-flight writes and reads are dropped; write data simply holds.
            occupancy   <= '0;
            rr_ptr      <= '0;
            fifo_wr_enb <= 1'b0;
            fifo_rd_enb <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            fifo_wr_enb <= gnt_any;
            if (gnt_any) begin
                fifo_wr_data <= req_arr[gnt_idx];
                rr_ptr       <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
            fifo_rd_enb <= do_rd;
            rd_valid    <= fifo_rd_enb;
            case ({gnt_any, do_rd})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            pop;
    logic            pop_ack;
    logic            rd_valid;
    logic            fifo_wr_enb;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_rd_enb;
    logic            fifo_rst;
    logic [CW-1:0]   occupancy;
    logic            full;
    logic            empty;

    fifo_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req(req), .req_data(req_data),
        .gnt(gnt), .pop(pop), .pop_ack(pop_ack), .rd_valid(rd_valid),
        .fifo_wr_enb(fifo_wr_enb), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_enb(fifo_rd_enb), .fifo_rst(fifo_rst),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Emulation of the downstream 8-entry FIFO, driven only by the DUT's FIFO-side outputs.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] fdout = '0;
    always @(posedge clk) begin
        if (fifo_rst === 1'b1) begin
            fq.delete();
        end else begin
            if (fifo_rd_enb === 1'b1 && fq.size() > 0) fdout = fq.pop_front();
            if (fifo_wr_enb === 1'b1) fq.push_back(fifo_wr_data);
        end
    end

    // Behavioural model: occupancy count, round-robin pointer, a queue of
    // accepted data, and the two-stage read pipeline.
    int            m_occ = 0;
    int            m_ptr = 0;
    bit            m_wr_enb, m_rd_enb, m_rd_valid, m_fifo_rst;
    logic [DW-1:0] m_wr_data;
    logic [DW-1:0] m_d1, m_d2;
    logic [DW-1:0] sbq[$];
    bit            started = 1'b0;
    int            mg, cg;
    bit            mp;

    function automatic int model_gnt();
        if (rst || flush || m_occ == DEPTH) return -1;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (((int'(req) >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst || flush) begin
            if (rst) begin
                m_wr_data = '0;
                started   = 1'b1;
            end
            m_occ = 0; m_ptr = 0;
            m_wr_enb = 0; m_rd_enb = 0; m_rd_valid = 0; m_fifo_rst = 1;
            sbq.delete();
        end else begin
            mg = model_gnt();
            mp = pop && (m_occ > 0);
            m_rd_valid = m_rd_enb;
            m_d2       = m_d1;
            m_rd_enb   = mp;
            m_wr_enb   = (mg >= 0);
            m_fifo_rst = 0;
            if (mp) m_d1 = sbq.pop_front();
            if (mg >= 0) begin
                m_wr_data = DW'(req_data >> (mg * DW));
                sbq.push_back(m_wr_data);
                m_ptr = (mg + 1) % N;
            end
            m_occ = m_occ + (mg >= 0 ? 1 : 0) - (mp ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cg = model_gnt();
            check("gnt", 32'(gnt), (cg < 0) ? 32'd0 : 32'(1 << cg));
            check("pop_ack", 32'(pop_ack), 32'(!rst && !flush && m_occ > 0));
            check("occupancy", 32'(occupancy), 32'(m_occ));
            check("full", 32'(full), 32'(m_occ == DEPTH));
            check("empty", 32'(empty), 32'(m_occ == 0));
            check("fifo_wr_enb", 32'(fifo_wr_enb), 32'(m_wr_enb));
            check("fifo_wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
            check("fifo_rd_enb", 32'(fifo_rd_enb), 32'(m_rd_enb));
            check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            check("fifo_rst", 32'(fifo_rst), 32'(m_fifo_rst));
            if (m_rd_valid) check("rd_data", 32'(fdout), 32'(m_d2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pop = 1'b0; req = '1;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick(); tick();
        // held in reset with every producer requesting
        @(negedge clk);
        check("h_gnt_in_rst", 32'(gnt), 32'd0);
        check("h_pop_ack_in_rst", 32'(pop_ack), 32'd0);
        check("h_occ_rst", 32'(occupancy), 32'd0);
        check("h_empty_rst", 32'(empty), 32'd1);
        check("h_fifo_rst_in_rst", 32'(fifo_rst), 32'd1);
        tick();
        rst = 1'b0; req = '0;
        @(negedge clk);
        check("h_fifo_rst_after", 32'(fifo_rst), 32'd1);
        tick();
        @(negedge clk);
        check("h_fifo_rst_drop", 32'(fifo_rst), 32'd0);
        tick();

        // all four requesting: grants rotate 0,1,2,3,0
        req = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("h_rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            if (k > 0) check("h_rr_data", 32'(fifo_wr_data), 32'(8'hA0 + (k - 1) % 4));
            tick();
        end
        req = '0;
        @(negedge clk);
        check("h_rr_data_last", 32'(fifo_wr_data), 32'h A0);
        check("h_occ5", 32'(occupancy), 32'd5);
        tick();
        pop = 1'b1;
        repeat (5) begin @(negedge clk); tick(); end
        pop = 1'b0;
        @(negedge clk);
        check("h_drained", 32'(occupancy), 32'd0);
        tick();

        // single producer fills to full; pop frees one slot
        req = 4'b0100;
        repeat (8) begin @(negedge clk); tick(); end
        @(negedge clk);
        check("h_occ_full", 32'(occupancy), 32'd8);
        check("h_full", 32'(full), 32'd1);
        check("h_gnt_full", 32'(gnt), 32'd0);
        tick();
        pop = 1'b1;
        @(negedge clk);
        check("h_gnt_full_pop", 32'(gnt), 32'd0);
        check("h_pop_ack_full", 32'(pop_ack), 32'd1);
        tick();
        pop = 1'b0;
        @(negedge clk);
        check("h_occ7", 32'(occupancy), 32'd7);
        check("h_regrant", 32'(gnt), 32'b0100);
        tick();
        req = '0;
        @(negedge clk);
        check("h_refull", 32'(occupancy), 32'd8);
        pop = 1'b1;
        tick();
        repeat (8) begin @(negedge clk); tick(); end
        pop = 1'b0;

        // write 0x55 then pop on the following edge
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'h55};
        req = 4'b0001;
        @(negedge clk);
        check("h_gnt0", 32'(gnt), 32'b0001);
        tick();
        req = '0; pop = 1'b1;
        @(negedge clk);
        check("h_pop_ack55", 32'(pop_ack), 32'd1);
        tick();
        pop = 1'b0;
        @(negedge clk);
        check("h_rd_enb", 32'(fifo_rd_enb), 32'd1);
        check("h_rd_valid_early", 32'(rd_valid), 32'd0);
        tick();
        @(negedge clk);
        check("h_rd_valid", 32'(rd_valid), 32'd1);
        check("h_dout55", 32'(fdout), 32'h55);
        check("h_rd_enb_off", 32'(fifo_rd_enb), 32'd0);
        tick();

        // concurrent write and pop at occupancy 3
        req = 4'b0010;
        repeat (3) begin @(negedge clk); tick(); end
        pop = 1'b1;
        @(negedge clk);
        check("h_occ3", 32'(occupancy), 32'd3);
        check("h_gnt1_pop", 32'(gnt), 32'b0010);
        tick();
        req = '0; pop = 1'b0;
        @(negedge clk);
        check("h_occ3_hold", 32'(occupancy), 32'd3);
        pop = 1'b1;
        tick();
        repeat (3) begin @(negedge clk); tick(); end
        // pop at zero with a concurrent write is refused
        req = 4'b1000;
        @(negedge clk);
        check("h_pop_ack_zero", 32'(pop_ack), 32'd0);
        check("h_gnt3", 32'(gnt), 32'b1000);
        tick();
        req = '0; pop = 1'b0;
        @(negedge clk);
        check("h_occ1", 32'(occupancy), 32'd1);
        pop = 1'b1;
        tick();
        @(negedge clk);
        tick();
        pop = 1'b0;

        // occupancy 5 then a one-cycle flush
        req = 4'b0010;
        repeat (5) begin @(negedge clk); tick(); end
        req = 4'b1001; flush = 1'b1;
        @(negedge clk);
        check("h_occ5_pre", 32'(occupancy), 32'd5);
        check("h_gnt_flush", 32'(gnt), 32'd0);
        check("h_pop_ack_flush", 32'(pop_ack), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("h_occ_flushed", 32'(occupancy), 32'd0);
        check("h_empty_flushed", 32'(empty), 32'd1);
        check("h_fifo_rst_flush", 32'(fifo_rst), 32'd1);
        check("h_gnt_after_flush", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        @(negedge clk);
        check("h_fifo_rst_once", 32'(fifo_rst), 32'd0);
        check("h_occ_after_flush", 32'(occupancy), 32'd1);
        tick();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
